key_filter: RTL and testbench

KEY_FILTER -- requirements
Module: key_filter

---
 rtl/key_filter.sv | 141 ++++++++++++++
 tb/tb_key_filter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/key_filter.sv
// key_filter: four independent push-button debouncers producing press, release,
// long-press pulses and a debounced held level per key.
module key_filter #(
  parameter int CNT_20MS = 1_000_000,
  parameter int CNT_LONG = 50_000_000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] key,
  output logic [3:0] key_flag,
  output logic [3:0] key_rel,
  output logic [3:0] key_state,
  output logic [3:0] key_long
);

  localparam int FW = (CNT_20MS > 1) ? $clog2(CNT_20MS) : 1;
  localparam int HW = (CNT_LONG > 1) ? $clog2(CNT_LONG) : 1;

  localparam logic [FW-1:0] FILT_MAX  = FW'(CNT_20MS - 1);
  localparam logic [FW-1:0] FILT_ONE  = FW'(1);
  localparam logic [FW-1:0] FILT_ZERO = {FW{1'b0}};
  localparam logic [HW-1:0] HOLD_MAX  = HW'(CNT_LONG - 1);
  localparam logic [HW-1:0] HOLD_PRE  = HW'(CNT_LONG - 2);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0] HOLD_ZERO = {HW{1'b0}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILT_DN = 2'd1,
    DOWN    = 2'd2,
    FILT_UP = 2'd3
  } state_t;

  logic [3:0]    key_r0;
  logic [3:0]    key_r1;
  logic [3:0]    key_s;
  state_t        state_r    [4];
  logic [FW-1:0] filt_cnt_r [4];
  logic [HW-1:0] hold_cnt_r [4];

  assign key_s = key_r1;

  // Two-flop synchronizer; resets to the released (high) level so reset never looks like a press.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      key_r0 <= 4'b1111;
      key_r1 <= 4'b1111;
    end else begin
      key_r0 <= key;
      key_r1 <= key_r0;
    end
  end

  // Per-key debounce FSM with filter/hold counters and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      key_flag  <= 4'b0000;
      key_rel   <= 4'b0000;
      key_state <= 4'b0000;
      key_long  <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        state_r[i]    <= IDLE;
        filt_cnt_r[i] <= FILT_ZERO;
        hold_cnt_r[i] <= HOLD_ZERO;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        key_flag[i] <= 1'b0;
        key_rel[i]  <= 1'b0;
        key_long[i] <= 1'b0;
        case (state_r[i])
          IDLE: begin
            key_state[i]  <= 1'b0;
            filt_cnt_r[i] <= FILT_ZERO;
            if (!key_s[i]) begin
              state_r[i] <= FILT_DN;
            end else begin
              state_r[i] <= IDLE;
            end
          end
          FILT_DN: begin
            key_state[i] <= 1'b0;
            if (key_s[i]) begin
              state_r[i]    <= IDLE;
              filt_cnt_r[i] <= FILT_ZERO;
            end else if (filt_cnt_r[i] == FILT_MAX) begin
              state_r[i]    <= DOWN;
              filt_cnt_r[i] <= FILT_ZERO;
              hold_cnt_r[i] <= HOLD_ZERO;
              key_flag[i]   <= 1'b1;
              key_state[i]  <= 1'b1;
            end else begin
              filt_cnt_r[i] <= filt_cnt_r[i] + FILT_ONE;
            end
          end
          DOWN: begin
            key_state[i] <= 1'b1;
            if (key_s[i]) begin
              state_r[i]    <= FILT_UP;
              filt_cnt_r[i] <= FILT_ZERO;
            end else begin
              state_r[i] <= DOWN;
            end
            // Saturating hold count; the long pulse fires only on the step into the top value.
            if (hold_cnt_r[i] != HOLD_MAX) begin
              hold_cnt_r[i] <= hold_cnt_r[i] + HOLD_ONE;
              if (hold_cnt_r[i] == HOLD_PRE) begin
                key_long[i] <= 1'b1;
              end else begin
                key_long[i] <= 1'b0;
              end
            end else begin
              hold_cnt_r[i] <= HOLD_MAX;
            end
          end
          FILT_UP: begin
            key_state[i] <= 1'b1;
            if (!key_s[i]) begin
              state_r[i]    <= DOWN;
              filt_cnt_r[i] <= FILT_ZERO;
            end else if (filt_cnt_r[i] == FILT_MAX) begin
              state_r[i]    <= IDLE;
              filt_cnt_r[i] <= FILT_ZERO;
              key_rel[i]    <= 1'b1;
              key_state[i]  <= 1'b0;
            end else begin
              filt_cnt_r[i] <= filt_cnt_r[i] + FILT_ONE;
            end
          end
          default: begin
            state_r[i]    <= IDLE;
            filt_cnt_r[i] <= FILT_ZERO;
            hold_cnt_r[i] <= HOLD_ZERO;
            key_state[i]  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_filter.sv
// Scoreboard bench for key_filter: a run-length reference model predicts every
// cycle's outputs, a negedge monitor compares, plus directed latency checks.
module tb_key_filter;

  localparam int CNT_20MS = 20;
  localparam int CNT_LONG = 100;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] key = 4'hF;
  logic [3:0] key_flag;
  logic [3:0] key_rel;
  logic [3:0] key_state;
  logic [3:0] key_long;

  int n_checks = 0;
  int n_fail = 0;

  logic [15:0] exp_q[$];
  int flag_cnt[4];
  int rel_cnt[4];
  int long_cnt[4];

  key_filter #(.CNT_20MS(CNT_20MS), .CNT_LONG(CNT_LONG)) dut (
    .clk(clk),
    .rstn(rstn),
    .key(key),
    .key_flag(key_flag),
    .key_rel(key_rel),
    .key_state(key_state),
    .key_long(key_long)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Reference model: a key's debounced level flips once the synchronized input has
  // disagreed with it for CNT_20MS+1 consecutive clocks; long-press counts clocks
  // spent held with no release pending.
  initial begin
    logic [3:0] sync0, sync1, level, f, r, l;
    logic pressed, steady_down;
    int run[4];
    int hold[4];
    sync0 = 4'hF; sync1 = 4'hF; level = 4'h0;
    for (int i = 0; i < 4; i++) begin run[i] = 0; hold[i] = 0; end
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        sync0 = 4'hF; sync1 = 4'hF; level = 4'h0;
        for (int i = 0; i < 4; i++) begin run[i] = 0; hold[i] = 0; end
        exp_q.delete();
      end else begin
        f = 4'h0; r = 4'h0; l = 4'h0;
        for (int i = 0; i < 4; i++) begin
          pressed = ~sync1[i];
          steady_down = level[i] && (run[i] == 0);
          if (pressed != level[i]) run[i]++;
          else run[i] = 0;
          if (run[i] == CNT_20MS + 1) begin
            level[i] = ~level[i];
            run[i] = 0;
            if (level[i]) begin f[i] = 1'b1; hold[i] = 0; end
            else r[i] = 1'b1;
          end
          if (steady_down && hold[i] < CNT_LONG - 1) begin
            hold[i]++;
            if (hold[i] == CNT_LONG - 1) l[i] = 1'b1;
          end
        end
        sync1 = sync0;
        sync0 = key;
        exp_q.push_back({f, r, level, l});
      end
    end
  end

  // Monitor: compares DUT outputs against the model every falling edge.
  initial begin
    logic [15:0] got, e;
    forever begin
      @(negedge clk);
      got = {key_flag, key_rel, key_state, key_long};
      if (!rstn) begin
        check("reset_outputs", got, 16'h0000);
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs", got, e);
        for (int i = 0; i < 4; i++) begin
          if (key_flag[i]) flag_cnt[i]++;
          if (key_rel[i])  rel_cnt[i]++;
          if (key_long[i]) long_cnt[i]++;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Called right after a stimulus change at posedge+2: the next edge is edge 0.
  task automatic check_latency(input int sel, input logic [3:0] exp);
    repeat (CNT_20MS + 2) @(posedge clk);
    #1;
    check(sel == 0 ? "flag_early" : "rel_early", {12'h000, sel == 0 ? key_flag : key_rel}, 16'h0000);
    @(posedge clk);
    #1;
    check(sel == 0 ? "flag_edge" : "rel_edge", {12'h000, sel == 0 ? key_flag : key_rel}, {12'h000, exp});
    @(posedge clk);
    #1;
    check(sel == 0 ? "flag_width" : "rel_width", {12'h000, sel == 0 ? key_flag : key_rel}, 16'h0000);
    #1;
  endtask

  initial begin
    int dur[4];
    for (int i = 0; i < 4; i++) begin flag_cnt[i] = 0; rel_cnt[i] = 0; long_cnt[i] = 0; end
    rstn = 1'b0;
    key = 4'hF;
    cyc(3);
    rstn = 1'b1;
    cyc(5);

    // Clean press and release on key 0
    key[0] = 1'b0;
    check_latency(0, 4'b0001);
    check("state_after_press", {12'h000, key_state}, 16'h0001);
    key[0] = 1'b1;
    check_latency(1, 4'b0001);
    check("state_after_release", {12'h000, key_state}, 16'h0000);
    cyc(5);

    // Bounce on key 1 must be rejected
    key[1] = 1'b0; cyc(5);
    key[1] = 1'b1; cyc(3);
    key[1] = 1'b0; cyc(8);
    key[1] = 1'b1; cyc(30);
    check("bounce_flag_cnt", 16'(flag_cnt[1]), 16'h0000);
    check("bounce_state", {12'h000, key_state}, 16'h0000);

    // Long press on key 2
    key[2] = 1'b0;
    check_latency(0, 4'b0100);
    repeat (CNT_LONG - 3) @(posedge clk);
    #1;
    check("long_early", {12'h000, key_long}, 16'h0000);
    @(posedge clk);
    #1;
    check("long_edge", {12'h000, key_long}, 16'h0004);
    #1;
    cyc(60);
    check("long_once", 16'(long_cnt[2]), 16'h0001);
    key[2] = 1'b1;
    cyc(30);

    // Release glitch on key 3
    key[3] = 1'b0; cyc(30);
    key[3] = 1'b1; cyc(10);
    key[3] = 1'b0; cyc(30);
    check("glitch_rel_cnt", 16'(rel_cnt[3]), 16'h0000);
    check("glitch_state", {12'h000, key_state}, 16'h0008);
    key[3] = 1'b1;
    check_latency(1, 4'b1000);
    cyc(5);

    // Simultaneous press on keys 0 and 3
    key = 4'b0110;
    check_latency(0, 4'b1001);
    key = 4'hF;
    cyc(30);

    // Reset while key 1 is held
    key[1] = 1'b0;
    cyc(30);
    check("held_before_reset", {12'h000, key_state}, 16'h0002);
    rstn = 1'b0;
    #1;
    check("reset_immediate", {key_flag, key_rel, key_state, key_long}, 16'h0000);
    cyc(3);
    rstn = 1'b1;
    check_latency(0, 4'b0010);
    key[1] = 1'b1;
    cyc(30);

    // Randomized bouncing and presses, with one mid-run reset
    for (int i = 0; i < 4; i++) dur[i] = $urandom_range(30, 1);
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 4; i++) begin
        dur[i]--;
        if (dur[i] <= 0) begin
          key[i] = ~key[i];
          dur[i] = ($urandom_range(3, 0) == 0) ? $urandom_range(160, 25) : $urandom_range(24, 1);
        end
      end
      if (c == 2000) rstn = 1'b0;
      if (c == 2003) rstn = 1'b1;
      cyc(1);
    end
    key = 4'hF;
    cyc(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
